// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue/writeback stage around a 16-bit ALU; optional perf counters via ALU_ISSUE_PERF_EN
module alu_issue_ctrl #(
    parameter int NREG = 8,
    parameter int DW   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ld_en,
    input  logic [2:0]      ld_addr,
    input  logic [DW-1:0]   ld_data,
    output logic            ld_ready,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [2:0]      cmd_op,
    input  logic [2:0]      cmd_rs1,
    input  logic [2:0]      cmd_rs2,
    input  logic [2:0]      cmd_rd,
    output logic [DW-1:0]   alu_inp1,
    output logic [DW-1:0]   alu_inp2,
    output logic [2:0]      alu_opcode,
    input  logic [2*DW-1:0] alu_result,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [2*DW-1:0] rsp_data,
    output logic            rsp_err
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [15:0]     perf_ops,
    output logic [7:0]      perf_dz
`endif
);

    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPRD,
        S_EXEC,
        S_WB,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DW-1:0]       r_regs [NREG];
    logic [2:0]          r_op;
    logic [2:0]          r_rs1;
    logic [2:0]          r_rs2;
    logic [2:0]          r_rd;
    logic                r_dz;
    logic [2*DW-1:0]     r_res;
    logic [DW-1:0]       w_rs2_val;
    logic [2:0]          w_rd_hi;
    logic                w_wide;
    logic                w_rsp_hs;

    assign w_rs2_val = r_regs[r_rs2];
    assign w_rd_hi   = r_rd + 3'd1;
    assign w_wide    = (r_op == OP_MUL) || (r_op == OP_DIV);
    assign w_rsp_hs  = rsp_valid && rsp_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake readiness; loads and commands only accepted in IDLE
    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        ld_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                ld_ready  = 1'b1;
                if (cmd_valid) begin
                    w_next = S_OPRD;
                end
            end
            S_OPRD:  w_next = S_EXEC;
            S_EXEC:  w_next = S_WB;
            S_WB:    w_next = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Register file: loads in IDLE, result writeback (low half, plus high half for mul/div) in WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_state == S_IDLE && ld_en) begin
            r_regs[ld_addr] <= ld_data;
        end else if (r_state == S_WB && !r_dz) begin
            r_regs[r_rd] <= r_res[DW-1:0];
            if (w_wide) begin
                r_regs[w_rd_hi] <= r_res[2*DW-1:DW];
            end
        end
    end

    // Command latch, operand issue, result capture and response register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_dz       <= 1'b0;
            r_res      <= '0;
            alu_inp1   <= '0;
            alu_inp2   <= '0;
            alu_opcode <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op  <= cmd_op;
                        r_rs1 <= cmd_rs1;
                        r_rs2 <= cmd_rs2;
                        r_rd  <= cmd_rd;
                    end
                end
                S_OPRD: begin
                    alu_inp1   <= r_regs[r_rs1];
                    alu_inp2   <= w_rs2_val;
                    alu_opcode <= r_op;
                    // 0x8000 is a negative zero to the ALU's divider, so it traps too
                    r_dz       <= (r_op == OP_DIV) &&
                                  (w_rs2_val[DW-2:0] == '0);
                end
                S_EXEC: begin
                    // The ALU output is undefined on a zero divisor; never sample it
                    r_res <= r_dz ? '0 : alu_result;
                end
                S_WB: begin
                    rsp_data  <= r_res;
                    rsp_err   <= r_dz;
                    rsp_valid <= 1'b1;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    // Response and trap counters, free-running with natural wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops <= '0;
            perf_dz  <= '0;
        end else if (w_rsp_hs) begin
            perf_ops <= perf_ops + 16'd1;
            if (rsp_err) begin
                perf_dz <= perf_dz + 8'd1;
            end
        end
    end
`else
    // Counters absent; the handshake strobe has no consumer in this build
    logic w_unused;
    assign w_unused = w_rsp_hs;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_rs1;
    logic [2:0]  cmd_rs2;
    logic [2:0]  cmd_rd;
    logic [15:0] alu_inp1;
    logic [15:0] alu_inp2;
    logic [2:0]  alu_opcode;
    logic [31:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
`ifdef ALU_ISSUE_PERF_EN
    logic [15:0] perf_ops;
    logic [7:0]  perf_dz;
`endif

    int n_pass;
    int n_total;

    alu_issue_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .cmd_rd     (cmd_rd),
        .alu_inp1   (alu_inp1),
        .alu_inp2   (alu_inp2),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .perf_ops   (perf_ops),
        .perf_dz    (perf_dz)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: signed add/sub/mul, magnitude divide {quotient, remainder}, zero-extended logic ops
    always_comb begin
        logic [31:0] a;
        logic [31:0] b;
        a = {{16{alu_inp1[15]}}, alu_inp1};
        b = {{16{alu_inp2[15]}}, alu_inp2};
        alu_result = 32'h0;
        case (alu_opcode)
            3'b000: alu_result = a + b;
            3'b001: alu_result = a - b;
            3'b010: alu_result = a * b;
            3'b011: begin
                if (alu_inp2[14:0] == 15'h0)
                    alu_result = 32'hDEAD_BEEF;
                else
                    alu_result = {1'b0, alu_inp1[14:0] / alu_inp2[14:0],
                                  1'b0, alu_inp1[14:0] % alu_inp2[14:0]};
            end
            3'b100: alu_result = {16'h0, alu_inp1 | alu_inp2};
            3'b101: alu_result = {16'h0, alu_inp1 & alu_inp2};
            3'b110: alu_result = {16'h0, ~alu_inp1};
            default: alu_result = {16'h0, ~alu_inp2};
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [2:0] rd);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rs1   = rs1;
        cmd_rs2   = rs2;
        cmd_rd    = rd;
        @(negedge clk);
        cmd_valid = 1'b0;
        ld_en     = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) check("rsp_timeout", 32'(rsp_valid), 32'd1);
    endtask

    task automatic run(input logic [2:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic [2:0] rd, output logic [31:0] d, output logic e,
                       output int lat);
        rsp_ready = 1'b1;
        issue(op, rs1, rs2, rd);
        wait_valid(lat);
        d = rsp_data;
        e = rsp_err;
        @(negedge clk);
    endtask

    task automatic read_reg(input logic [2:0] r, output logic [15:0] v);
        logic [31:0] d;
        logic        e;
        int          lat;
        run(3'b100, r, r, r, d, e, lat);
        v = d[15:0];
    endtask

    logic [31:0] d;
    logic        e;
    int          lat;
    logic [15:0] v;

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        ld_en     = 1'b0;
        ld_addr   = 3'd0;
        ld_data   = 16'h0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_rs1   = 3'd0;
        cmd_rs2   = 3'd0;
        cmd_rd    = 3'd0;
        rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_alu_inp1", 32'(alu_inp1), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_ld_ready", 32'(ld_ready), 32'd1);

        // Signed add
        load(3'd1, 16'h0005);
        load(3'd2, 16'hFFFD);
        run(3'b000, 3'd1, 3'd2, 3'd3, d, e, lat);
        check("add_lat", 32'(lat), 32'd3);
        check("add_data", d, 32'h0000_0002);
        check("add_err", 32'(e), 32'd0);
        read_reg(3'd3, v);
        check("add_r3", 32'(v), 32'h0002);

        // Multiply with high-half wrap from r7 to r0
        load(3'd4, 16'hFFFE);
        load(3'd5, 16'h0003);
        run(3'b010, 3'd4, 3'd5, 3'd7, d, e, lat);
        check("mul_lat", 32'(lat), 32'd3);
        check("mul_data", d, 32'hFFFF_FFFA);
        read_reg(3'd7, v);
        check("mul_r7", 32'(v), 32'hFFFA);
        read_reg(3'd0, v);
        check("mul_r0", 32'(v), 32'hFFFF);

        // Divide, then trap on 0x8000 and 0x0000 divisors
        load(3'd1, 16'h0007);
        load(3'd2, 16'h0002);
        run(3'b011, 3'd1, 3'd2, 3'd3, d, e, lat);
        check("div_data", d, 32'h0003_0001);
        check("div_err", 32'(e), 32'd0);
        read_reg(3'd3, v);
        check("div_r3", 32'(v), 32'h0001);
        read_reg(3'd4, v);
        check("div_r4", 32'(v), 32'h0003);
        load(3'd2, 16'h8000);
        run(3'b011, 3'd1, 3'd2, 3'd3, d, e, lat);
        check("dz8k_data", d, 32'h0);
        check("dz8k_err", 32'(e), 32'd1);
        read_reg(3'd3, v);
        check("dz8k_r3", 32'(v), 32'h0001);
        read_reg(3'd4, v);
        check("dz8k_r4", 32'(v), 32'h0003);
        load(3'd2, 16'h0000);
        run(3'b011, 3'd1, 3'd2, 3'd3, d, e, lat);
        check("dz0_data", d, 32'h0);
        check("dz0_err", 32'(e), 32'd1);

        // Load and command in the same cycle: command sees the new value
        ld_en   = 1'b1;
        ld_addr = 3'd6;
        ld_data = 16'h1234;
        run(3'b100, 3'd6, 3'd6, 3'd6, d, e, lat);
        check("ldcmd_data", d, 32'h0000_1234);

        // Destination equals source
        run(3'b000, 3'd1, 3'd1, 3'd1, d, e, lat);
        check("rdsrc_data", d, 32'h0000_000E);
        read_reg(3'd1, v);
        check("rdsrc_r1", 32'(v), 32'h000E);

        // Response back-pressure with a dropped load
        rsp_ready = 1'b0;
        issue(3'b110, 3'd1, 3'd2, 3'd6);
        wait_valid(lat);
        check("bp_lat", 32'(lat), 32'd3);
        for (int i = 0; i < 10; i++) begin
            ld_en   = 1'b1;
            ld_addr = 3'd5;
            ld_data = 16'hAAAA;
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_data", rsp_data, 32'h0000_FFF1);
            check("bp_err", 32'(rsp_err), 32'd0);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_ld_ready", 32'(ld_ready), 32'd0);
            @(negedge clk);
        end
        ld_en     = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(rsp_valid), 32'd0);
        check("bp_release_idle", 32'(cmd_ready), 32'd1);
        read_reg(3'd5, v);
        check("bp_r5_kept", 32'(v), 32'h0003);
        read_reg(3'd6, v);
        check("bp_r6", 32'(v), 32'hFFF1);

        // Asynchronous reset in EXEC
        rsp_ready = 1'b1;
        issue(3'b000, 3'd1, 3'd5, 3'd2);
        @(negedge clk);
        check("exec_inp1", 32'(alu_inp1), 32'h000E);
        rst_n = 1'b0;
        #1;
        check("arst_inp1", 32'(alu_inp1), 32'h0);
        check("arst_inp2", 32'(alu_inp2), 32'h0);
        check("arst_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_idle", 32'(cmd_ready), 32'd1);
        read_reg(3'd1, v);
        check("arst_r1", 32'(v), 32'h0);
        read_reg(3'd5, v);
        check("arst_r5", 32'(v), 32'h0);
        load(3'd1, 16'h0003);
        load(3'd2, 16'h0004);
        run(3'b010, 3'd1, 3'd2, 3'd2, d, e, lat);
        check("post_lat", 32'(lat), 32'd3);
        check("post_data", d, 32'h0000_000C);

`ifdef ALU_ISSUE_PERF_EN
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("perf_ops_rst", 32'(perf_ops), 32'd0);
        check("perf_dz_rst", 32'(perf_dz), 32'd0);
        load(3'd1, 16'h0009);
        run(3'b000, 3'd1, 3'd1, 3'd3, d, e, lat);
        run(3'b011, 3'd1, 3'd2, 3'd3, d, e, lat);
        run(3'b101, 3'd1, 3'd1, 3'd4, d, e, lat);
        check("perf_ops", 32'(perf_ops), 32'd3);
        check("perf_dz", 32'(perf_dz), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
